// File: rtl/pc_gen_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_stage_pkg
//  Description : Shared types and constants for the fetch PC generator:
//                address type, reset PC and exception vector, FSM encodings,
//                and the PC increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_stage_pkg;

    typedef logic [31:0] addr_t;

    localparam addr_t c_reset_pc_default = 32'hBFC0_0000;
    localparam addr_t c_exc_vector       = 32'hBFC0_0380;
    localparam addr_t c_inst_bytes       = 32'd4;

    // SEQ: no branch pending; WAIT_DS: target latched, delay slot not yet
    // accepted; GO: delay slot accepted, target currently presented.
    typedef enum logic [1:0] {
        PCG_SEQ     = 2'd0,
        PCG_WAIT_DS = 2'd1,
        PCG_GO      = 2'd2
    } pcg_state_e;

    // Next sequential instruction address, wrapping modulo 2^32.
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + c_inst_bytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_stage_if
//  Description : Fetch handshake plus decode/writeback redirect bundle for
//                the PC generator. master = PC generator, slave = the
//                fetch/decode/writeback side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_stage_if
    import pc_gen_stage_pkg::*;
    ;
    logic  valid_o;
    addr_t pc_o;
    logic  ready_i;
    logic  br_taken_i;
    addr_t br_pc_i;
    addr_t br_target_i;
    logic  flush_i;
    addr_t flush_target_i;
    logic  pending_o;

    modport master (
        output valid_o, pc_o, pending_o,
        input  ready_i, br_taken_i, br_pc_i, br_target_i, flush_i, flush_target_i
    );

    modport slave (
        input  valid_o, pc_o, pending_o,
        output ready_i, br_taken_i, br_pc_i, br_target_i, flush_i, flush_target_i
    );
endinterface
`default_nettype wire

// File: rtl/pc_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_stage
//  Description : Fetch PC generator with MIPS delay-slot branch handling and
//                exception/ERET flush redirects. The PC is only consumed on
//                valid_o && ready_i; all outputs come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_stage
    import pc_gen_stage_pkg::*;
#(
    parameter addr_t RESET_PC = c_reset_pc_default
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    pc_gen_stage_if.master  bus
);

    pcg_state_e r_state;
    logic       r_valid;
    addr_t      r_pc;
    addr_t      r_br_tgt;
    addr_t      r_ds_addr;
    addr_t      r_last_pc;

    pcg_state_e w_state_nxt;
    addr_t      w_pc_nxt;
    addr_t      w_br_tgt_nxt;
    addr_t      w_ds_addr_nxt;
    addr_t      w_last_pc_nxt;
    addr_t      w_br_ds;
    addr_t      w_pc_seq;
    logic       w_hs;

    // Next-state / next-PC selection: flush beats branch apply beats sequential.
    always_comb begin
        w_hs          = r_valid && bus.ready_i;
        // Delay-slot check must see an acceptance happening on this same edge.
        w_last_pc_nxt = w_hs ? r_pc : r_last_pc;
        w_br_ds       = pc_inc(bus.br_pc_i);
        w_pc_seq      = pc_inc(r_pc);
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_br_tgt_nxt  = r_br_tgt;
        w_ds_addr_nxt = r_ds_addr;

        if (bus.flush_i) begin
            // Redirect replaces pc_o even when stalled; any latched branch is lost.
            w_pc_nxt    = bus.flush_target_i;
            w_state_nxt = PCG_SEQ;
        end else begin
            unique case (r_state)
                PCG_SEQ: begin
                    if (w_hs) begin
                        w_pc_nxt = w_pc_seq;
                    end
                    if (bus.br_taken_i) begin
                        w_br_tgt_nxt  = bus.br_target_i;
                        w_ds_addr_nxt = w_br_ds;
                        if (w_last_pc_nxt == w_br_ds) begin
                            // Delay slot already fetched: present the target now.
                            w_state_nxt = PCG_GO;
                            w_pc_nxt    = bus.br_target_i;
                        end else begin
                            w_state_nxt = PCG_WAIT_DS;
                        end
                    end
                end
                PCG_WAIT_DS: begin
                    if (w_hs) begin
                        if (r_pc == r_ds_addr) begin
                            w_pc_nxt    = r_br_tgt;
                            w_state_nxt = PCG_SEQ;
                        end else begin
                            w_pc_nxt = w_pc_seq;
                        end
                    end
                end
                PCG_GO: begin
                    if (w_hs) begin
                        w_pc_nxt    = pc_inc(r_br_tgt);
                        w_state_nxt = PCG_SEQ;
                    end
                end
                default: begin
                    w_state_nxt = PCG_SEQ;
                end
            endcase
        end
    end

    // State register; valid rises on the first edge after reset and stays high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= PCG_SEQ;
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_br_tgt  <= '0;
            r_ds_addr <= '0;
            r_last_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= 1'b1;
            r_pc      <= w_pc_nxt;
            r_br_tgt  <= w_br_tgt_nxt;
            r_ds_addr <= w_ds_addr_nxt;
            r_last_pc <= w_last_pc_nxt;
        end
    end

    assign bus.valid_o   = r_valid;
    assign bus.pc_o      = r_pc;
    assign bus.pending_o = (r_state != PCG_SEQ);

`ifndef SYNTHESIS
    // A taken branch inside a delay slot is a decoder bug; the pulse is dropped.
    a_no_branch_in_ds : assert property (@(posedge clk) disable iff (!resetn)
        !(bus.br_taken_i && !bus.flush_i && (r_state != PCG_SEQ)))
        else $error("pc_gen_stage: br_taken_i while a branch is pending");
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen_stage
//  Description : Directed table-driven bench for pc_gen_stage plus hand
//                sequences for asynchronous reset during a stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen_stage;
    import pc_gen_stage_pkg::*;

    typedef struct {
        logic  ready;
        logic  br;
        addr_t br_pc;
        addr_t br_tgt;
        logic  fl;
        addr_t fl_tgt;
        logic  e_valid;
        addr_t e_pc;
        logic  e_pend;
    } vec_t;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    pc_gen_stage_if bus ();

    pc_gen_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input addr_t epc, input logic ep);
        chk({tag, ".valid"},   {31'd0, bus.valid_o},   {31'd0, ev});
        chk({tag, ".pc"},      bus.pc_o,               epc);
        chk({tag, ".pending"}, {31'd0, bus.pending_o}, {31'd0, ep});
    endtask

    task automatic drive(input logic r, input logic b, input addr_t bpc, input addr_t btgt,
                         input logic f, input addr_t ftgt);
        bus.ready_i        = r;
        bus.br_taken_i     = b;
        bus.br_pc_i        = bpc;
        bus.br_target_i    = btgt;
        bus.flush_i        = f;
        bus.flush_target_i = ftgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic b, input addr_t bpc, input addr_t btgt,
                       input logic f, input addr_t ftgt,
                       input logic ev, input addr_t epc, input logic ep);
        vec_t v;
        v.ready = r; v.br = b; v.br_pc = bpc; v.br_tgt = btgt;
        v.fl = f; v.fl_tgt = ftgt;
        v.e_valid = ev; v.e_pc = epc; v.e_pend = ep;
        vecs.push_back(v);
    endtask

    // Shorthand for a plain cycle with only ready_i driven.
    task automatic add_seq(input logic r, input addr_t epc, input logic ep);
        add(r, 1'b0, '0, '0, 1'b0, '0, 1'b1, epc, ep);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        resetn = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Sequential fetch from reset: first edge only raises valid.
        add(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hBFC00000, 1'b0);
        add_seq(1'b1, 32'hBFC00004, 1'b0);
        add_seq(1'b1, 32'hBFC00008, 1'b0);
        add_seq(1'b1, 32'hBFC0000C, 1'b0);
        add_seq(1'b1, 32'hBFC00010, 1'b0);
        // Five-cycle stall holds pc_o, release advances by one.
        for (int i = 0; i < 5; i++) add_seq(1'b0, 32'hBFC00010, 1'b0);
        add_seq(1'b1, 32'hBFC00014, 1'b0);
        // Branch at BFC00000 while its delay slot BFC00004 is still unaccepted.
        add(1'b0, 1'b0, '0, '0, 1'b1, 32'hBFC00004, 1'b1, 32'hBFC00004, 1'b0);
        add(1'b0, 1'b1, 32'hBFC00000, 32'h80001000, 1'b0, '0, 1'b1, 32'hBFC00004, 1'b1);
        add_seq(1'b0, 32'hBFC00004, 1'b1);
        add_seq(1'b1, 32'h80001000, 1'b0);
        add_seq(1'b1, 32'h80001004, 1'b0);
        // Same branch with the delay slot already accepted: target held in GO.
        add(1'b0, 1'b0, '0, '0, 1'b1, 32'hBFC00004, 1'b1, 32'hBFC00004, 1'b0);
        add_seq(1'b1, 32'hBFC00008, 1'b0);
        add(1'b0, 1'b1, 32'hBFC00000, 32'h80001000, 1'b0, '0, 1'b1, 32'h80001000, 1'b1);
        add_seq(1'b0, 32'h80001000, 1'b1);
        add_seq(1'b0, 32'h80001000, 1'b1);
        add_seq(1'b1, 32'h80001004, 1'b0);
        // Flush together with a branch: branch ignored.
        add(1'b1, 1'b1, 32'h80001000, 32'h12345678, 1'b1, c_exc_vector, 1'b1, 32'hBFC00380, 1'b0);
        add_seq(1'b1, 32'hBFC00384, 1'b0);
        // Flush while waiting for a delay slot: latched branch discarded.
        add(1'b0, 1'b1, 32'hBFC00390, 32'h90000000, 1'b0, '0, 1'b1, 32'hBFC00384, 1'b1);
        add(1'b1, 1'b0, '0, '0, 1'b1, c_exc_vector, 1'b1, 32'hBFC00380, 1'b0);
        add_seq(1'b1, 32'hBFC00384, 1'b0);
        add_seq(1'b1, 32'hBFC00388, 1'b0);
        add_seq(1'b1, 32'hBFC0038C, 1'b0);
        add_seq(1'b1, 32'hBFC00390, 1'b0);
        add_seq(1'b1, 32'hBFC00394, 1'b0);
        add_seq(1'b1, 32'hBFC00398, 1'b0);
        // Address wrap, and a delay slot address that wraps to zero.
        add(1'b0, 1'b0, '0, '0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b0);
        add_seq(1'b1, 32'h00000000, 1'b0);
        add_seq(1'b1, 32'h00000004, 1'b0);
        add(1'b0, 1'b1, 32'hFFFFFFFC, 32'h00400000, 1'b0, '0, 1'b1, 32'h00400000, 1'b1);
        add_seq(1'b1, 32'h00400004, 1'b0);

        // Reset state.
        tick();
        tick();
        chk_all("reset", 1'b0, 32'hBFC00000, 1'b0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ready, vecs[i].br, vecs[i].br_pc, vecs[i].br_tgt,
                  vecs[i].fl, vecs[i].fl_tgt);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_pend);
        end

        // Asynchronous reset in the middle of a stalled branch wait.
        drive(1'b0, 1'b1, 32'h00000100, 32'h00800000, 1'b0, '0);
        tick();
        chk_all("stall_wait", 1'b1, 32'h00400004, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 32'hBFC00000, 1'b0);
        tick();
        resetn = 1'b1;
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
        tick();
        chk_all("restart0", 1'b1, 32'hBFC00000, 1'b0);
        tick();
        chk_all("restart1", 1'b1, 32'hBFC00004, 1'b0);
        tick();
        chk_all("restart2", 1'b1, 32'hBFC00008, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
